// File: rtl/reorder_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reorder_buffer_if: issue, CDB, operand query, commit and flush signals    |
// | between the out-of-order core and the reorder buffer.                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface reorder_buffer_if #(
   parameter int ROB_AW = 4,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              issue_valid;
   logic [REG_W-1:0]  issue_rd;
   logic              issue_is_branch;
   logic              issue_ready;
   logic [ROB_AW-1:0] issue_tag;

   logic              cdb_valid;
   logic [ROB_AW-1:0] cdb_tag;
   logic [DATA_W-1:0] cdb_value;
   logic              cdb_mispredict;
   logic [DATA_W-1:0] cdb_target;

   logic [ROB_AW-1:0] q1_tag;
   logic              q1_ready;
   logic [DATA_W-1:0] q1_value;
   logic [ROB_AW-1:0] q2_tag;
   logic              q2_ready;
   logic [DATA_W-1:0] q2_value;

   logic              commit_valid;
   logic [ROB_AW-1:0] commit_tag;
   logic [REG_W-1:0]  updated_index;
   logic [DATA_W-1:0] updated_value;
   logic              jump_wrong;
   logic [DATA_W-1:0] jump_target;

   modport master (
      output issue_valid, issue_rd, issue_is_branch,
      input  issue_ready, issue_tag,
      output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
      output q1_tag, q2_tag,
      input  q1_ready, q1_value, q2_ready, q2_value,
      input  commit_valid, commit_tag, updated_index, updated_value,
      input  jump_wrong, jump_target
   );

   modport slave (
      input  issue_valid, issue_rd, issue_is_branch,
      output issue_ready, issue_tag,
      input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
      input  q1_tag, q2_tag,
      output q1_ready, q1_value, q2_ready, q2_value,
      output commit_valid, commit_tag, updated_index, updated_value,
      output jump_wrong, jump_target
   );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reorder_buffer: circular in-order-retire buffer with CDB capture, operand |
// | look-up and mispredict flush. Optional macro ROB_BYPASS_EN forwards CDB.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module reorder_buffer #(
   parameter int ROB_DEPTH = 16,
   parameter int ROB_AW    = 4,
   parameter int DATA_W    = 32,
   parameter int REG_W     = 5
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        rdy,
   reorder_buffer_if.slave  bus
);
   localparam logic [ROB_AW:0] c_depth = (ROB_AW+1)'(ROB_DEPTH);

   logic              r_busy       [ROB_DEPTH];
   logic              r_ready      [ROB_DEPTH];
   logic [REG_W-1:0]  r_rd         [ROB_DEPTH];
   logic [DATA_W-1:0] r_value      [ROB_DEPTH];
   logic              r_is_branch  [ROB_DEPTH];
   logic              r_mispredict [ROB_DEPTH];
   logic [DATA_W-1:0] r_target     [ROB_DEPTH];

   logic [ROB_AW-1:0] r_head, r_tail;
   logic [ROB_AW:0]   r_count;
   logic              r_flush_pending;

   logic              r_commit_valid, r_jump_wrong;
   logic [ROB_AW-1:0] r_commit_tag;
   logic [REG_W-1:0]  r_updated_index;
   logic [DATA_W-1:0] r_updated_value, r_jump_target;

   logic              w_issue, w_cdb_wr, w_head_rdy, w_commit, w_jump, w_commit_mis;
   logic [DATA_W-1:0] w_commit_value, w_commit_target;

   assign bus.issue_ready   = (r_count < c_depth) && !r_flush_pending;
   assign bus.issue_tag     = r_tail;
   assign bus.commit_valid  = r_commit_valid;
   assign bus.commit_tag    = r_commit_tag;
   assign bus.updated_index = r_updated_index;
   assign bus.updated_value = r_updated_value;
   assign bus.jump_wrong    = r_jump_wrong;
   assign bus.jump_target   = r_jump_target;

   always_comb begin
      w_issue         = rdy && bus.issue_valid && bus.issue_ready;
      w_cdb_wr        = rdy && bus.cdb_valid && r_busy[bus.cdb_tag] && !r_flush_pending;
      w_commit_value  = r_value[r_head];
      w_commit_mis    = r_mispredict[r_head];
      w_commit_target = r_target[r_head];
`ifdef ROB_BYPASS_EN
      // A head entry completing this cycle retires straight from the CDB.
      w_head_rdy = r_ready[r_head] ||
                   (bus.cdb_valid && bus.cdb_tag == r_head && r_busy[r_head]);
      if (!r_ready[r_head]) begin
         w_commit_value  = bus.cdb_value;
         w_commit_mis    = bus.cdb_mispredict;
         w_commit_target = bus.cdb_target;
      end
`else
      w_head_rdy = r_ready[r_head];
`endif
      w_commit = rdy && !r_flush_pending && (r_count != '0) && w_head_rdy;
      w_jump   = w_commit && r_is_branch[r_head] && w_commit_mis;
   end

   always_comb begin
      bus.q1_ready = r_busy[bus.q1_tag] && r_ready[bus.q1_tag];
      bus.q1_value = r_value[bus.q1_tag];
      bus.q2_ready = r_busy[bus.q2_tag] && r_ready[bus.q2_tag];
      bus.q2_value = r_value[bus.q2_tag];
`ifdef ROB_BYPASS_EN
      if (bus.cdb_valid && bus.cdb_tag == bus.q1_tag && r_busy[bus.q1_tag]) begin
         bus.q1_ready = 1'b1;
         bus.q1_value = bus.cdb_value;
      end
      if (bus.cdb_valid && bus.cdb_tag == bus.q2_tag && r_busy[bus.q2_tag]) begin
         bus.q2_ready = 1'b1;
         bus.q2_value = bus.cdb_value;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_flush_pending <= 1'b0;
         r_commit_valid  <= 1'b0;
         r_commit_tag    <= '0;
         r_updated_index <= '0;
         r_updated_value <= '0;
         r_jump_wrong    <= 1'b0;
         r_jump_target   <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_busy[i]  <= 1'b0;
            r_ready[i] <= 1'b0;
         end
      end else if (!rdy) begin
         r_commit_valid <= 1'b0;
         r_jump_wrong   <= 1'b0;
      end else if (r_flush_pending) begin
         for (int i = 0; i < ROB_DEPTH; i++) r_busy[i] <= 1'b0;
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_flush_pending <= 1'b0;
         r_commit_valid  <= 1'b0;
         r_jump_wrong    <= 1'b0;
      end else begin
         r_commit_valid <= w_commit;
         r_jump_wrong   <= w_jump;
         if (w_cdb_wr) r_ready[bus.cdb_tag] <= 1'b1;
         if (w_commit) begin
            r_busy[r_head]  <= 1'b0;
            r_head          <= r_head + ROB_AW'(1);
            r_commit_tag    <= r_head;
            r_updated_index <= r_rd[r_head];
            r_updated_value <= w_commit_value;
         end
         if (w_jump) begin
            r_jump_target   <= w_commit_target;
            r_flush_pending <= 1'b1;
         end
         // A full buffer never issues, so tail cannot collide with head here.
         if (w_issue) begin
            r_busy[r_tail]  <= 1'b1;
            r_ready[r_tail] <= 1'b0;
            r_tail          <= r_tail + ROB_AW'(1);
         end
         r_count <= r_count + (ROB_AW+1)'(w_issue) - (ROB_AW+1)'(w_commit);
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_rd[r_tail]         <= bus.issue_rd;
         r_is_branch[r_tail]  <= bus.issue_is_branch;
         r_mispredict[r_tail] <= 1'b0;
      end
      if (w_cdb_wr) begin
         r_value[bus.cdb_tag]      <= bus.cdb_value;
         r_mispredict[bus.cdb_tag] <= bus.cdb_mispredict;
         r_target[bus.cdb_tag]     <= bus.cdb_target;
      end
   end
endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer for the Tomasulo out-of-order core.
- Sits directly upstream of the register file.
- Allocates one entry per issued instruction and captures results broadcast on the CDB.
- Retires entries in program order. Each retirement drives the register-file update port (updated_index/updated_value) and the jump_wrong flush.
- Also answers operand look-ups by ROB tag for the dispatch stage.

Parameters:
ROB_DEPTH, 16, number of entries; power of two.
ROB_AW, 4, log2(ROB_DEPTH); tag width.
DATA_W, 32, data and PC width.
REG_W, 5, architectural register index width.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-low
rdy  in  1  global enable; when low all state holds
issue_valid  in  1  allocate one entry this cycle
issue_rd  in  REG_W  destination register of the issued instruction
issue_is_branch  in  1  instruction is a branch or jump
issue_ready  out  1  combinational; high when count < ROB_DEPTH and no flush is pending
issue_tag  out  ROB_AW  combinational; tail index that the issuing instruction receives
cdb_valid  in  1  result broadcast
cdb_tag  in  ROB_AW  entry being completed
cdb_value  in  DATA_W  result value
cdb_mispredict  in  1  branch resolved against its prediction
cdb_target  in  DATA_W  correct next PC for a mispredicted branch
q1_tag  in  ROB_AW  operand look-up tag, port 1
q1_ready  out  1  combinational; entry q1_tag is busy and its result is present
q1_value  out  DATA_W  combinational; value of entry q1_tag
q2_tag  in  ROB_AW  operand look-up tag, port 2
q2_ready  out  1  as q1_ready, for q2_tag
q2_value  out  DATA_W  as q1_value, for q2_tag
commit_valid  out  1  registered; one-cycle pulse, an entry retired
commit_tag  out  ROB_AW  registered; tag of the retired entry
updated_index  out  REG_W  registered; rd of the retired entry
updated_value  out  DATA_W  registered; value of the retired entry
jump_wrong  out  1  registered; one-cycle flush pulse
jump_target  out  DATA_W  registered; redirect PC, valid while jump_wrong is high

Behaviour:
- Per-entry state: busy, ready, rd, value, is_branch, mispredict, target.
- Pointers: head, tail (ROB_AW bits each, wrap modulo ROB_DEPTH) and count (ROB_AW+1 bits).
- Reset (rst=0, asynchronous): head=tail=count=0; all busy/ready bits cleared; every registered output is 0.
- rdy=0: all state holds; commit_valid and jump_wrong are forced to 0 on the next edge.
- Issue, on an edge with issue_valid && issue_ready:
  - entry[tail] gets busy=1, ready=0, mispredict=0, rd and is_branch loaded;
  - tail increments.
  - issue_valid while issue_ready=0 is ignored; no state change.
- CDB write: if entry[cdb_tag] is busy, load value, mispredict and target, and set ready=1. A write to a non-busy tag is ignored.
- Commit: at most one entry per cycle, when count>0 and entry[head] is ready.
  - Next edge: commit_valid=1, commit_tag=head, updated_index=rd, updated_value=value.
  - entry[head].busy clears; head increments.
  - rd=0 commits unchanged; the register file ignores x0.
- Mispredict on commit: if the retiring entry has is_branch and mispredict set, the same edge also sets jump_wrong=1 and jump_target=target, and raises a flush-pending flag.
- Flush, on the next edge:
  - all busy bits cleared; head=tail=count=0; flush-pending cleared;
  - no commit takes place;
  - issue_ready=0 during the pending cycle;
  - CDB writes in that cycle are discarded.
- Simultaneous events:
  - Issue and commit on the same edge: count is unchanged.
  - A CDB write to entry[head] becomes commit-eligible on the following cycle, not the same cycle (in the base build).
  - Full: count==ROB_DEPTH, so issue_ready=0. A commit that cycle frees a slot only from the next cycle.
- Wrap-around: tail 15→0 and head 15→0 with no bubble.
- Latency:
  - Issue to tag visible on the query ports: 1 cycle.
  - CDB to q*_ready: 1 cycle.
  - Ready to commit_valid: 1 cycle.

Optional Feature:
ROB_BYPASS_EN
- Defined:
  - When cdb_valid and cdb_tag==q*_tag and that entry is busy, q*_ready=1 and q*_value=cdb_value in the same cycle.
  - Entry[head] may commit on the same edge its CDB write arrives, using the CDB value, mispredict and target.
- Undefined: query ports and commit see only registered entry contents; each has one extra cycle of latency.

Test Plan:
1. Reset: hold rst=0 with issue_valid=1 for 3 cycles -> issue_ready=1, issue_tag=0, commit_valid=0 and jump_wrong=0 throughout.
2. In-order commit of out-of-order results:
   - issue rd=5 (tag 0), then rd=6 (tag 1);
   - CDB tag1=0x22, then tag0=0x11;
   - -> commits tag0 (5,0x11), then tag1 (6,0x22), on consecutive cycles.
3. Full/wrap: issue 16 with no CDB -> issue_ready=0 at count 16. Complete tag0, then issue once more -> new entry gets tag 0; count stays 16.
4. Mispredict:
   - issue branch (tag 2) behind two ALU ops;
   - CDB tag2 mispredict=1, target=0x100, plus the ALU results;
   - -> after the 2 ALU commits, jump_wrong=1 with jump_target=0x100 for one cycle;
   - next cycle count=0, and a later issue gets tag 0.
5. rdy stall: drop rdy for 4 cycles while the head is ready -> no commit_valid and pointers unchanged; commit occurs 1 cycle after rdy returns.
6. Bypass:
   - with ROB_BYPASS_EN, CDB tag3=0xAB while q1_tag=3 -> q1_ready=1, q1_value=0xAB in the same cycle;
   - without it, q1_ready rises one cycle later.
